multi_pre_fetch_stage: RTL and testbench
========================================

Name: multi_pre_fetch_stage

Overview:
- Parametrised successor to the single-instruction pre-fetch stage.
- Fetches FETCH_WIDTH-instruction aligned groups from the ICache and keeps up to MAX_OUTSTANDING requests in flight.
- Buffers returned groups in an in-order BUF_DEPTH queue feeding the fetch stage through a valid/ready handshake.
- On redirect, drops stale in-flight responses by counting them out, so no request is ever cancelled at the cache.

Parameters:
- FETCH_WIDTH, 2: instructions per group; power of two, 1..4.
- MAX_OUTSTANDING, 2: maximum accepted but unanswered ICache requests; 1..4.
- BUF_DEPTH, 4: output queue entries; must be >= MAX_OUTSTANDING.
- RESET_PC, 32'hbfc0_0000: first fetch address after reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- redirect_valid  in  1  flush and restart (exception, eret, branch correction, cache/tlb op).
- redirect_pc  in  32  restart address.
- icache_req  out  1  request valid.
- icache_addr  out  32  group address; low log2(FETCH_WIDTH)+2 bits forced to 0.
- icache_addr_ok  in  1  request accepted this cycle.
- icache_data_ok  in  1  oldest accepted request returns this cycle.
- icache_rdata  in  32*FETCH_WIDTH  lane i = instruction at group base + 4*i.
- icache_ex  in  1  TLB exception on the returned group.
- icache_exccode  in  5  exception code.
- out_valid  out  1  head entry valid.
- out_ready  in  1  fetch stage accepts the head entry.
- out_pc  out  32  PC of the first valid lane.
- out_inst  out  32*FETCH_WIDTH  instruction lanes.
- out_mask  out  FETCH_WIDTH  valid lanes.
- out_ex  out  1  entry carries an exception.
- out_exccode  out  5  exception code.

Behaviour:
- Reset (resetn=0 at a clk edge): fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty, halted=0. Outputs during and after reset: icache_req=0 and out_valid=0 in the reset cycle; all other outputs 0.
- Issue condition: icache_req=1 iff resetn & !halted & !redirect_valid & outstanding<MAX_OUTSTANDING & (outstanding+drop_cnt+occupancy)<BUF_DEPTH. This guarantees every response has a queue slot.
- Request hold: icache_req and icache_addr stay stable until icache_addr_ok.
- On accept: fetch_pc <= aligned(fetch_pc)+4*FETCH_WIDTH; outstanding++.
- Lane mask: each request carries the mask of lanes with index >= fetch_pc word offset, so the first group after a redirect may be partial. Masks travel in a MAX_OUTSTANDING-entry tag FIFO together with the exact fetch_pc.
- Response: on icache_data_ok with drop_cnt=0, push {pc, rdata, mask, ex, exccode}; outstanding--.
- Stale response: on icache_data_ok with drop_cnt>0, drop_cnt-- and no push.
- Address error: if fetch_pc[1:0]!=0, issue no request; push one entry with ex=1, exccode=5'h04 (AdEL), mask=0, pc=fetch_pc; set halted=1.
- Exception halt: a pushed entry with icache_ex=1 sets halted=1. All later responses are dropped: drop_cnt+=outstanding.
- Halt release: halted clears only on redirect.
- Redirect (one cycle, highest priority):
  - queue cleared.
  - drop_cnt <= drop_cnt+outstanding, counting a same-cycle addr_ok and excluding a same-cycle data_ok.
  - outstanding <= 0, tag FIFO cleared, fetch_pc <= redirect_pc, halted <= 0.
  - No request issued in the redirect cycle.
- Queue:
  - Circular buffer with wrap-around head/tail pointers.
  - Simultaneous push and pop when full is legal.
  - Pop when out_valid & out_ready.
  - Never overflows, enforced by the issue condition; overflow fires an assertion in simulation.
- Latency: without bypass, data_ok at cycle N gives out_valid at N+1.
- Reset mid-operation clears all state. Responses arriving after reset are not counted; the cache interface is reset together with this block.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when the queue is empty, drop_cnt=0 and a response arrives, the response drives out_* combinationally in the same cycle.
  - out_ready=1: consumed without enqueue.
  - out_ready=0: enqueued normally.
- Undefined: every response goes through the queue with one cycle of latency.

Test Plan:
- Reset release, FETCH_WIDTH=2, cache with 1-cycle accept and 1-cycle response -> addresses bfc00000, bfc00008, bfc00010 issued. Entries arrive in order with mask=2'b11 and out_pc equal to each address.
- Redirect to 0x80000004 with 2 requests in flight -> next 2 data_ok responses dropped. First new entry has pc=80000004 and mask=2'b10; next has pc=80000008 and mask=2'b11.
- out_ready held 0 -> requests stop once outstanding+occupancy=4. No data lost; after release, 4 entries drain in order and issuing resumes.
- Redirect to 0x80000002 -> no icache_req. One entry with ex=1, exccode=5'h04, mask=0; halted until the next redirect.
- Response with icache_ex=1, exccode=5'h02 while a second request is in flight -> entry delivered with ex=1 and the second response dropped. No requests until redirect.
- PREFETCH_BYPASS_EN, empty queue, out_ready=1 -> out_valid in the same cycle as data_ok. Without the macro -> out_valid one cycle later.

Source files
------------

// File: rtl/multi_pre_fetch_stage.sv
// multi_pre_fetch_stage: pipelined group pre-fetch with in-order queue; PREFETCH_BYPASS_EN adds same-cycle response bypass
module multi_pre_fetch_stage #(
  parameter int FETCH_WIDTH = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BUF_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     icache_req,
  output logic [31:0]              icache_addr,
  input  logic                     icache_addr_ok,
  input  logic                     icache_data_ok,
  input  logic [32*FETCH_WIDTH-1:0] icache_rdata,
  input  logic                     icache_ex,
  input  logic [4:0]               icache_exccode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [32*FETCH_WIDTH-1:0] out_inst,
  output logic [FETCH_WIDTH-1:0]   out_mask,
  output logic                     out_ex,
  output logic [4:0]               out_exccode
);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int TW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] GROUP = 32'(4 * FETCH_WIDTH);
  localparam logic [31:0] AMASK = ~(GROUP - 32'd1);
  typedef struct packed {
    logic [31:0]              pc;
    logic [32*FETCH_WIDTH-1:0] inst;
    logic [FETCH_WIDTH-1:0]   mask;
    logic                     ex;
    logic [4:0]               exccode;
  } entry_t;
  typedef struct packed {
    logic [31:0]            pc;
    logic [FETCH_WIDTH-1:0] mask;
  } tag_t;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d, out_nxt;
  logic [CW-1:0] drop_q, drop_d, count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic halted_q, halted_d;
  entry_t mem_q [BUF_DEPTH];
  entry_t mem_d [BUF_DEPTH];
  tag_t tag_q [MAX_OUTSTANDING];
  tag_t tag_d [MAX_OUTSTANDING];
  logic [31:0] word_off;
  logic [FETCH_WIDTH-1:0] req_mask;
  logic misal, space, adel, acc, stale, good, ex_halt, flush, byp, push, pop;
  entry_t resp_e, push_e, head_e;
  // Request/response decode, queue head selection and gated outputs
  always_comb begin
    word_off = (fetch_pc_q & ~AMASK) >> 2;
    for (int i = 0; i < FETCH_WIDTH; i++) req_mask[i] = word_off <= 32'(i);
    misal = |fetch_pc_q[1:0];
    space = int'(outstanding_q) + int'(drop_q) + int'(count_q) < BUF_DEPTH;
    icache_req = resetn && !halted_q && !redirect_valid && !misal && int'(outstanding_q) < MAX_OUTSTANDING && space;
    icache_addr = icache_req ? fetch_pc_q & AMASK : '0;
    adel = resetn && !halted_q && !redirect_valid && misal && outstanding_q == '0 && space;
    acc = icache_req && icache_addr_ok;
    stale = icache_data_ok && drop_q != '0;
    good = icache_data_ok && drop_q == '0 && outstanding_q != '0;
    ex_halt = good && icache_ex;
    flush = redirect_valid || ex_halt;
    out_nxt = outstanding_q + OW'(acc) - OW'(good);
    resp_e = '{pc: tag_q[tag_rd_q].pc, inst: icache_rdata, mask: tag_q[tag_rd_q].mask, ex: icache_ex, exccode: icache_exccode};
    push_e = adel ? '{pc: fetch_pc_q, inst: '0, mask: '0, ex: 1'b1, exccode: 5'h04} : resp_e;
`ifdef PREFETCH_BYPASS_EN
    byp = good && count_q == '0 && !redirect_valid;
`else
    byp = 1'b0;
`endif
    head_e = byp ? resp_e : mem_q[head_q];
    out_valid = resetn && (count_q != '0 || byp);
    pop = out_valid && out_ready && count_q != '0;
    push = (good || adel) && !(byp && out_ready);
    out_pc = out_valid ? head_e.pc : '0;
    out_inst = out_valid ? head_e.inst : '0;
    out_mask = out_valid ? head_e.mask : '0;
    out_ex = out_valid && head_e.ex;
    out_exccode = out_valid ? head_e.exccode : '0;
  end
  // Next state: redirect flushes everything, an exception halt turns in-flight requests into drops
  always_comb begin
    fetch_pc_d = redirect_valid ? redirect_pc : acc ? (fetch_pc_q & AMASK) + GROUP : fetch_pc_q;
    halted_d = !redirect_valid && (halted_q || ex_halt || adel);
    outstanding_d = flush ? '0 : out_nxt;
    drop_d = drop_q - CW'(stale) + (flush ? CW'(out_nxt) : '0);
    tag_d = tag_q;
    if (acc) tag_d[tag_wr_q] = '{pc: fetch_pc_q, mask: req_mask};
    tag_wr_d = flush ? '0 : acc ? (tag_wr_q == TW'(MAX_OUTSTANDING - 1) ? '0 : tag_wr_q + 1'b1) : tag_wr_q;
    tag_rd_d = flush ? '0 : good ? (tag_rd_q == TW'(MAX_OUTSTANDING - 1) ? '0 : tag_rd_q + 1'b1) : tag_rd_q;
    mem_d = mem_q;
    if (push) mem_d[tail_q] = push_e;
    tail_d = redirect_valid ? '0 : push ? (tail_q == PW'(BUF_DEPTH - 1) ? '0 : tail_q + 1'b1) : tail_q;
    head_d = redirect_valid ? '0 : pop ? (head_q == PW'(BUF_DEPTH - 1) ? '0 : head_q + 1'b1) : head_q;
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      outstanding_q <= '0;
      drop_q <= '0;
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
      halted_q <= 1'b0;
      mem_q <= '{default: '0};
      tag_q <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q <= drop_d;
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
      halted_q <= halted_d;
      mem_q <= mem_d;
      tag_q <= tag_d;
    end
  end
  // The issue condition reserves a slot for every response; a push into a full queue is a design bug
  always_ff @(posedge clk) begin
    if (resetn && !redirect_valid) assert (!(push && !pop && count_q == CW'(BUF_DEPTH)));
  end
endmodule

// File: tb/tb_multi_pre_fetch_stage.sv
// tb_multi_pre_fetch_stage: directed checks of issue, drop, backpressure, exceptions and response latency
module tb_multi_pre_fetch_stage;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn, redirect_valid, icache_req, icache_addr_ok, icache_data_ok, icache_ex;
  logic out_valid, out_ready, out_ex;
  logic [31:0] redirect_pc, icache_addr, out_pc;
  logic [63:0] icache_rdata, out_inst;
  logic [4:0] icache_exccode, out_exccode;
  logic [1:0] out_mask;
  int tests = 0;
  int fails = 0;
  multi_pre_fetch_stage dut (
    .clk(clk), .resetn(resetn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_req(icache_req), .icache_addr(icache_addr), .icache_addr_ok(icache_addr_ok),
    .icache_data_ok(icache_data_ok), .icache_rdata(icache_rdata), .icache_ex(icache_ex),
    .icache_exccode(icache_exccode), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_mask(out_mask), .out_ex(out_ex), .out_exccode(out_exccode)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic aok, input logic dok, input logic rdy, input logic [63:0] rd);
    icache_addr_ok = aok;
    icache_data_ok = dok;
    out_ready = rdy;
    icache_rdata = rd;
    icache_ex = 1'b0;
    icache_exccode = 5'h00;
    redirect_valid = 1'b0;
  endtask
  initial begin
    resetn = 1'b0;
    redirect_pc = '0;
    set(0, 0, 0, 64'h0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", icache_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_addr", icache_addr, 32'h0);
    resetn = 1'b1;
    set(1, 0, 0, 64'h0);
    #1;
    chk("c0_req", icache_req, 1'b1);
    chk("c0_addr", icache_addr, 32'hbfc00000);
    nxt(); set(1, 1, 0, {32'h10000001, 32'h10000000}); #1;
    chk("c1_addr", icache_addr, 32'hbfc00008);
    chk("c1_latency", out_valid, BYP);
    nxt(); set(1, 1, 1, {32'h20000001, 32'h20000000}); #1;
    chk("c2_valid", out_valid, 1'b1);
    chk("c2_pc", out_pc, 32'hbfc00000);
    chk("c2_mask", out_mask, 2'b11);
    chk("c2_inst", out_inst, {32'h10000001, 32'h10000000});
    chk("c2_addr", icache_addr, 32'hbfc00010);
    nxt(); set(0, 1, 1, {32'h30000001, 32'h30000000}); #1;
    chk("c3_pc", out_pc, 32'hbfc00008);
    chk("c3_inst", out_inst, {32'h20000001, 32'h20000000});
    chk("c3_addr", icache_addr, 32'hbfc00018);
    nxt(); set(1, 0, 1, 64'h0); #1;
    chk("c4_pc", out_pc, 32'hbfc00010);
    chk("c4_hold_addr", icache_addr, 32'hbfc00018);
    nxt(); set(1, 0, 1, 64'h0); #1;
    chk("c5_valid", out_valid, 1'b0);
    chk("c5_addr", icache_addr, 32'hbfc00020);
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c6_max_out", icache_req, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h80000004; #1;
    chk("c6_redir_req", icache_req, 1'b0);
    nxt(); set(1, 1, 1, 64'hdeaddeaddeaddead); #1;
    chk("c7_req", icache_req, 1'b1);
    chk("c7_addr", icache_addr, 32'h80000000);
    nxt(); set(1, 1, 1, 64'hdeaddeaddeaddead); #1;
    chk("c8_addr", icache_addr, 32'h80000008);
    chk("c8_stale_valid", out_valid, 1'b0);
    nxt(); set(0, 1, 0, {32'h40000001, 32'h40000000}); #1;
    chk("c9_req", icache_req, 1'b0);
    nxt(); set(0, 1, 1, {32'h50000001, 32'h50000000}); #1;
    chk("c10_pc", out_pc, 32'h80000004);
    chk("c10_mask", out_mask, 2'b10);
    chk("c10_inst", out_inst, {32'h40000001, 32'h40000000});
    chk("c10_addr", icache_addr, 32'h80000010);
    nxt(); set(1, 0, 0, 64'h0); #1;
    chk("c11_pc", out_pc, 32'h80000008);
    chk("c11_mask", out_mask, 2'b11);
    chk("c11_inst", out_inst, {32'h50000001, 32'h50000000});
    nxt(); set(1, 1, 0, {32'h60000001, 32'h60000000}); #1;
    chk("c12_addr", icache_addr, 32'h80000018);
    nxt(); set(1, 1, 0, {32'h70000001, 32'h70000000}); #1;
    chk("c13_addr", icache_addr, 32'h80000020);
    nxt(); set(0, 1, 0, {32'h80000001, 32'h80000000}); #1;
    chk("c14_full_req", icache_req, 1'b0);
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c15_full_req", icache_req, 1'b0);
    chk("c15_pc", out_pc, 32'h80000008);
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c16_pc", out_pc, 32'h80000010);
    chk("c16_inst", out_inst, {32'h60000001, 32'h60000000});
    chk("c16_resume", icache_req, 1'b1);
    chk("c16_addr", icache_addr, 32'h80000028);
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c17_pc", out_pc, 32'h80000018);
    chk("c17_inst", out_inst, {32'h70000001, 32'h70000000});
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c18_pc", out_pc, 32'h80000020);
    chk("c18_inst", out_inst, {32'h80000001, 32'h80000000});
    nxt(); set(0, 0, 1, 64'h0); redirect_valid = 1'b1; redirect_pc = 32'h80000002; #1;
    chk("c19_empty", out_valid, 1'b0);
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c20_adel_req", icache_req, 1'b0);
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c21_valid", out_valid, 1'b1);
    chk("c21_ex", out_ex, 1'b1);
    chk("c21_code", out_exccode, 5'h04);
    chk("c21_mask", out_mask, 2'b00);
    chk("c21_pc", out_pc, 32'h80000002);
    chk("c21_req", icache_req, 1'b0);
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c22_valid", out_valid, 1'b0);
    chk("c22_halted", icache_req, 1'b0);
    nxt(); set(0, 0, 1, 64'h0); redirect_valid = 1'b1; redirect_pc = 32'hbfc00100; #1;
    nxt(); set(1, 0, 1, 64'h0); #1;
    chk("c23_req", icache_req, 1'b1);
    chk("c23_addr", icache_addr, 32'hbfc00100);
    nxt(); set(1, 0, 1, 64'h0); #1;
    chk("c24_addr", icache_addr, 32'hbfc00108);
    nxt(); set(0, 1, 1, {32'h90000001, 32'h90000000}); icache_ex = 1'b1; icache_exccode = 5'h02; #1;
    chk("c25_req", icache_req, 1'b0);
    chk("c25_latency", out_valid, BYP);
    chk("c25_ex", out_ex, BYP);
    chk("c25_code", out_exccode, BYP ? 5'h02 : 5'h00);
    nxt(); set(0, 1, 1, {32'ha0000001, 32'ha0000000}); #1;
    chk("c26_valid", out_valid, !BYP);
    chk("c26_ex", out_ex, !BYP);
    chk("c26_code", out_exccode, BYP ? 5'h00 : 5'h02);
    chk("c26_pc", out_pc, BYP ? 32'h0 : 32'hbfc00100);
    chk("c26_req", icache_req, 1'b0);
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c27_dropped", out_valid, 1'b0);
    chk("c27_halted", icache_req, 1'b0);
    nxt(); set(0, 0, 1, 64'h0); redirect_valid = 1'b1; redirect_pc = 32'hbfc00200; #1;
    nxt(); set(0, 0, 1, 64'h0); #1;
    chk("c29_req", icache_req, 1'b1);
    chk("c29_addr", icache_addr, 32'hbfc00200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
